divider_ratio_meter: RTL and testbench

- Receive-side companion to the even clock divider: samples a divided clock generated from the same fast clock and measures its period and high time in fast-clock cycles.
- Checks the measurement against an expected divide factor.
- Reports lock once the ratio is stable.
- Sits beside divider instances as an on-chip self-check and monitor feeding status logic.

---
 rtl/divider_ratio_meter.sv | 164 ++++++++++++++++
 tb/tb_divider_ratio_meter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_ratio_meter.sv
// divider_ratio_meter
//   Monitors a divided clock generated from the same fast clock. Measures
//   the period (rise to rise) and the high time of div_in in clk cycles,
//   compares them with an expected even divide factor and reports lock once
//   LOCK_COUNT consecutive identical measurements have been seen.
//
// Ports
//   clk        fast reference clock, all logic on posedge
//   reset      asynchronous, active-high reset
//   enable     synchronous measurement enable
//   div_in     divided clock under test, already synchronous to clk
//   expected   expected divide factor N, sampled with each measurement
//   period     last measured period in clk cycles
//   high_time  clk samples with div_in=1 in the last period
//   valid      one-cycle pulse when period/high_time/mismatch update
//   mismatch   last measurement disagreed with expected (or N odd)
//   locked     LOCK_COUNT consecutive identical measurements seen
//   timeout    no rising edge within 2^WIDTH-1 cycles
module divider_ratio_meter #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LOCK_COUNT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_in,
    input  logic [WIDTH-1:0] expected,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             mismatch,
    output logic             locked,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       LOCK_MAX = 4'(LOCK_COUNT);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             prev;
    logic             rise;
    logic [WIDTH-1:0] hi_cnt;
    logic [WIDTH-1:0] lo_cnt;
    logic [WIDTH-1:0] sum;
    logic [3:0]       match_cnt;
    logic [3:0]       match_nx;
    logic             same;
    logic             do_start;
    logic             do_meas;
    logic             do_timeout;
    logic             do_count;

    assign rise = div_in & ~prev;
    // Bounded by the timeout rule: sum never exceeds CNT_MAX.
    assign sum  = hi_cnt + lo_cnt;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; enable=0 overrides everything, including a rise.
    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (rise) state_nx = MEASURE;
                MEASURE: if (!rise && sum == CNT_MAX) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Control strobes and lock-counter update
    always_comb begin
        do_start   = 1'b0;
        do_meas    = 1'b0;
        do_timeout = 1'b0;
        do_count   = 1'b0;
        if (enable) begin
            case (state)
                IDLE:    do_start = rise;
                MEASURE: begin
                    if (rise)                do_meas    = 1'b1;
                    else if (sum == CNT_MAX) do_timeout = 1'b1;
                    else                     do_count   = 1'b1;
                end
                default: ;
            endcase
        end

        // period/high_time still hold the previous measurement here; a zero
        // match counter marks the first measurement since IDLE.
        same = (sum == period) && (hi_cnt == high_time);
        if (match_cnt == 4'd0 || !same) begin
            match_nx = 4'd1;
        end else if (match_cnt >= LOCK_MAX) begin
            match_nx = LOCK_MAX;
        end else begin
            match_nx = match_cnt + 4'd1;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev      <= 1'b0;
            hi_cnt    <= '0;
            lo_cnt    <= '0;
            match_cnt <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            mismatch  <= 1'b0;
            locked    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            prev  <= div_in;
            valid <= 1'b0;
            if (!enable) begin
                hi_cnt    <= '0;
                lo_cnt    <= '0;
                match_cnt <= '0;
                locked    <= 1'b0;
                timeout   <= 1'b0;
            end else if (do_start) begin
                hi_cnt <= WIDTH'(1);
                lo_cnt <= '0;
            end else if (do_meas) begin
                period    <= sum;
                high_time <= hi_cnt;
                hi_cnt    <= WIDTH'(1);
                lo_cnt    <= '0;
                valid     <= 1'b1;
                mismatch  <= (sum != expected) || (hi_cnt != (expected >> 1)) || expected[0];
                match_cnt <= match_nx;
                locked    <= (match_nx == LOCK_MAX);
                timeout   <= 1'b0;
            end else if (do_timeout) begin
                hi_cnt    <= '0;
                lo_cnt    <= '0;
                match_cnt <= '0;
                locked    <= 1'b0;
                timeout   <= 1'b1;
            end else if (do_count) begin
                if (div_in) hi_cnt <= hi_cnt + WIDTH'(1);
                else        lo_cnt <= lo_cnt + WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_divider_ratio_meter.sv
// tb_divider_ratio_meter
//   Drives divided-clock waveforms into divider_ratio_meter, checks every
//   cycle against a queue-based reference model, and checks table rows and
//   hand-written corner sequences against constant expectations.
module tb_divider_ratio_meter;

    localparam int unsigned W  = 8;
    localparam int unsigned LC = 3;
    localparam int          TMO_LIMIT = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         div_in;
    logic [W-1:0] expected;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         mismatch;
    logic         locked;
    logic         timeout;

    always #5 clk = ~clk;

    divider_ratio_meter #(
        .WIDTH      (W),
        .LOCK_COUNT (LC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .div_in    (div_in),
        .expected  (expected),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .mismatch  (mismatch),
        .locked    (locked),
        .timeout   (timeout)
    );

    int n_vec = 0;
    int n_err = 0;
    int valid_cnt = 0;
    int ph = 0;
    bit drv_prev = 1'b0;

    // ---------------- reference model ----------------
    bit m_prev, m_armed, m_valid, m_mm, m_locked, m_tmo;
    int m_period, m_high;
    bit q[$];     // samples since the last counted rise
    int hist[$];  // measurements since IDLE, encoded period*1000+high

    function automatic void model_reset();
        m_prev = 0; m_armed = 0; m_valid = 0; m_mm = 0; m_locked = 0; m_tmo = 0;
        m_period = 0; m_high = 0;
        q.delete();
        hist.delete();
    endfunction

    function automatic void model_edge(bit en, bit d, int e);
        bit r;
        int ones, run;
        r = d && !m_prev;
        m_prev = d;
        m_valid = 0;
        if (!en) begin
            m_armed = 0; m_locked = 0; m_tmo = 0;
            q.delete();
            hist.delete();
        end else if (!m_armed) begin
            if (r) begin
                m_armed = 1;
                q.delete();
                q.push_back(1'b1);
            end
        end else if (r) begin
            ones = 0;
            foreach (q[i]) if (q[i]) ones++;
            m_period = q.size();
            m_high   = ones;
            m_valid  = 1;
            m_mm     = (m_period != e) || (m_high != e / 2) || (e % 2 != 0);
            hist.push_back(m_period * 1000 + m_high);
            if (hist.size() > 16) void'(hist.pop_front());
            run = 0;
            for (int i = hist.size() - 1; i >= 0; i--) begin
                if (hist[i] != hist[hist.size() - 1]) break;
                run++;
            end
            m_locked = (run >= LC);
            m_tmo = 0;
            q.delete();
            q.push_back(1'b1);
        end else if (q.size() == TMO_LIMIT) begin
            m_tmo = 1; m_locked = 0; m_armed = 0;
            q.delete();
            hist.delete();
        end else begin
            q.push_back(d);
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge(enable, div_in, int'(expected));
        #1;
        check("period",    int'(period),    m_period);
        check("high_time", int'(high_time), m_high);
        check("valid",     int'(valid),     int'(m_valid));
        check("mismatch",  int'(mismatch),  int'(m_mm));
        check("locked",    int'(locked),    int'(m_locked));
        check("timeout",   int'(timeout),   int'(m_tmo));
        if (valid) valid_cnt++;
    endtask

    task automatic gen_step(input int h, input int l);
        div_in = (ph < h);
        step();
        drv_prev = div_in;
        ph = (ph + 1) % (h + l);
    endtask

    task automatic run_pattern(input int h, input int l, input int n);
        ph = 0;
        for (int i = 0; i < n * (h + l); i++) gen_step(h, l);
    endtask

    typedef struct {
        int h;
        int l;
        int e;
        int n;
        int p;
        int hi;
        int mm;
        int lk;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int base, k, rises, gap_valids;

        //        h  l  e  n  period high mm locked
        tbl[0] = '{2, 2, 4, 6, 4, 2, 0, 1};
        tbl[1] = '{3, 3, 4, 6, 6, 3, 1, 1};
        tbl[2] = '{1, 4, 5, 6, 5, 1, 1, 1};
        tbl[3] = '{2, 2, 0, 6, 4, 2, 1, 1};
        tbl[4] = '{4, 4, 8, 6, 8, 4, 0, 1};
        tbl[5] = '{1, 1, 2, 6, 2, 1, 0, 1};
        tbl[6] = '{5, 3, 8, 6, 8, 5, 1, 1};
        tbl[7] = '{2, 2, 4, 3, 4, 2, 0, 0};

        model_reset();
        reset = 1'b1; enable = 1'b1; div_in = 1'b0; expected = 8'd4;

        // Reset sequence
        step();
        step();
        check("rst_period", int'(period), 0);
        check("rst_locked", int'(locked), 0);
        reset = 1'b0;
        run_pattern(2, 2, 1);
        check("first_rise_no_valid", valid_cnt, 0);
        run_pattern(2, 2, 1);
        check("second_rise_valid", valid_cnt, 1);
        check("rs_period", int'(period), 4);
        check("rs_high", int'(high_time), 2);
        check("rs_mm", int'(mismatch), 0);
        check("rs_locked_v1", int'(locked), 0);
        run_pattern(2, 2, 1);
        check("rs_locked_v2", int'(locked), 0);
        run_pattern(2, 2, 1);
        check("rs_valids", valid_cnt, 3);
        check("rs_locked_v3", int'(locked), 1);

        // Ratio change 4 -> 6 with a 2-high/3-low transitional period
        run_pattern(2, 3, 1);
        run_pattern(3, 3, 1);
        check("tr_period", int'(period), 5);
        check("tr_high", int'(high_time), 2);
        check("tr_mm", int'(mismatch), 1);
        check("tr_locked", int'(locked), 0);
        run_pattern(3, 3, 2);
        check("d6_period", int'(period), 6);
        check("d6_high", int'(high_time), 3);
        check("d6_mm", int'(mismatch), 1);
        check("d6_locked_2", int'(locked), 0);
        run_pattern(3, 3, 1);
        check("d6_locked_3", int'(locked), 1);

        // Odd/unbalanced input and expected=0
        expected = 8'd5;
        run_pattern(1, 4, 3);
        check("odd_period", int'(period), 5);
        check("odd_high", int'(high_time), 1);
        check("odd_mm", int'(mismatch), 1);
        expected = 8'd0;
        run_pattern(2, 2, 3);
        check("exp0_mm", int'(mismatch), 1);

        // Table rows
        for (int i = 0; i < 8; i++) begin
            expected = W'(tbl[i].e);
            run_pattern(tbl[i].h, tbl[i].l, tbl[i].n);
            check("tbl_period", int'(period), tbl[i].p);
            check("tbl_high", int'(high_time), tbl[i].hi);
            check("tbl_mm", int'(mismatch), tbl[i].mm);
            check("tbl_locked", int'(locked), tbl[i].lk);
        end

        // Stuck-low input: timeout 255 counted cycles after the last rise
        expected = 8'd4;
        run_pattern(2, 2, 4);
        div_in = 1'b1;
        step();
        div_in = 1'b0;
        k = 0;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (timeout) begin
                k = i;
                break;
            end
        end
        check("tmo_cycles", k, 255);
        check("tmo_locked", int'(locked), 0);
        check("tmo_period_hold", int'(period), 4);
        base = valid_cnt;
        run_pattern(2, 2, 1);
        check("tmo_first_rise_no_valid", valid_cnt - base, 0);
        check("tmo_still_set", int'(timeout), 1);
        run_pattern(2, 2, 1);
        check("tmo_second_rise_valid", valid_cnt - base, 1);
        check("tmo_cleared", int'(timeout), 0);

        // Enable gap during locked divide-by-4
        run_pattern(2, 2, 4);
        check("gap_pre_locked", int'(locked), 1);
        enable = 1'b0;
        base = valid_cnt;
        ph = 0;
        for (int i = 0; i < 9; i++) gen_step(2, 2);
        gap_valids = valid_cnt - base;
        check("gap_valids", gap_valids, 0);
        check("gap_locked", int'(locked), 0);
        check("gap_period_hold", int'(period), 4);
        enable = 1'b1;
        rises = 0;
        base = valid_cnt;
        for (int i = 0; i < 40; i++) begin
            if (ph == 0) rises++;
            gen_step(2, 2);
            if (valid_cnt != base) break;
        end
        check("reenable_valid_rise", rises, 2);

        // Async reset mid-period while locked
        run_pattern(2, 2, 5);
        check("ar_pre_locked", int'(locked), 1);
        #3;
        reset = 1'b1;
        #1;
        check("ar_period", int'(period), 0);
        check("ar_high", int'(high_time), 0);
        check("ar_valid", int'(valid), 0);
        check("ar_mm", int'(mismatch), 0);
        check("ar_locked", int'(locked), 0);
        check("ar_timeout", int'(timeout), 0);
        model_reset();
        div_in = 1'b0;
        step();
        reset = 1'b0;
        run_pattern(2, 2, 4);
        check("ar_reacq_locked", int'(locked), 1);
        check("ar_reacq_period", int'(period), 4);

        // Randomized waveforms against the model
        for (int seg = 0; seg < 120; seg++) begin
            int h, l, n;
            h = $urandom_range(1, 7);
            l = $urandom_range(1, 7);
            n = $urandom_range(1, 5);
            if ($urandom_range(0, 1) == 0) expected = W'(h + l);
            else                           expected = W'($urandom_range(0, 15));
            enable = ($urandom_range(0, 7) != 0);
            run_pattern(h, l, n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
